// File: rtl/gyro_spi_reader.sv
// gyro_spi_reader: SPI mode-3 master for a three-axis gyro.
// After reset it writes CTRL_REG1 (0x20 <- 0x0F) once, then burst-reads
// OUT_X_L..OUT_Z_H every SAMPLE_PERIOD cycles and presents signed 16-bit
// rates on DX/DY/DZ with a one-cycle VALID strobe.
// Optional build macro: GYRO_DEADBAND_EN. When defined, values strictly
// between DB_LO and DB_HI are forced to zero at latch time.
module gyro_spi_reader #(
   parameter int CLK_DIV       = 50,
   parameter int SAMPLE_PERIOD = 100000,
   parameter int DB_LO         = -42,
   parameter int DB_HI         = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               EN,
   output logic               SCLK,
   output logic               CS_N,
   output logic               MOSI,
   input  logic               MISO,
   output logic signed [15:0] DX,
   output logic signed [15:0] DY,
   output logic signed [15:0] DZ,
   output logic               VALID,
   output logic               BUSY,
   output logic               CFG_DONE
);

   localparam int DATA_W = 16;
   localparam int DIV_W  = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int TMR_W  = $clog2(SAMPLE_PERIOD + 1);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

   // Elaboration-time sanity checks on the parameter set.
   if (CLK_DIV < 2) begin : g_bad_div
      $error("gyro_spi_reader: CLK_DIV must be at least 2");
   end
   if (SAMPLE_PERIOD <= 114 * CLK_DIV) begin : g_bad_period
      $error("gyro_spi_reader: SAMPLE_PERIOD must exceed 114*CLK_DIV");
   end
   if (DB_LO >= DB_HI) begin : g_bad_deadband
      $error("gyro_spi_reader: DB_LO must be below DB_HI");
   end

   typedef enum logic [1:0] {
      S_CFG,
      S_WAIT,
      S_READ,
      S_LATCH
   } state_t;

   state_t                    state_q;
   logic                      cs_n_q;
   logic                      sclk_q;
   logic                      mosi_q;
   logic                      valid_q;
   logic                      cfg_done_q;
   logic [DIV_W-1:0]          div_q;
   logic [DIV_W-1:0]          gap_q;
   logic [2:0]                bit_q;
   logic [2:0]                byte_q;
   logic [TMR_W-1:0]          timer_q;
   logic [TMR_W-1:0]          timer_d;
   logic                      pending_q;
   logic                      pending_d;
   logic [47:0]               rx_q;
   logic signed [DATA_W-1:0]  dx_q;
   logic signed [DATA_W-1:0]  dy_q;
   logic signed [DATA_W-1:0]  dz_q;

   logic                      tick;
   logic                      start_rd;
   logic                      in_frame;
   logic                      div_evt;
   logic [2:0]                last_byte;
   logic [7:0]                tx_cur;
   logic                      tx_bit;

   // Byte the master shifts out for the given frame type and byte index.
   function automatic logic [7:0] tx_byte(input logic is_cfg, input logic [2:0] idx);
      logic [7:0] b;
      if (is_cfg) begin
         b = (idx == 3'd0) ? 8'h20 : 8'h0F;
      end else begin
         b = (idx == 3'd0) ? 8'hE8 : 8'h00;
      end
      return b;
   endfunction

   // Optional deadband: small rates around zero are reported as zero.
   function automatic logic signed [DATA_W-1:0] deadband(input logic signed [DATA_W-1:0] v);
      logic signed [DATA_W-1:0] r;
`ifdef GYRO_DEADBAND_EN
      localparam logic signed [DATA_W-1:0] DB_LO_S = DATA_W'(DB_LO);
      localparam logic signed [DATA_W-1:0] DB_HI_S = DATA_W'(DB_HI);
      r = ((v > DB_LO_S) && (v < DB_HI_S)) ? '0 : v;
`else
      r = v;
`endif
      return r;
   endfunction

   // Timer, request and bit-engine decode.
   always_comb begin
      tick      = cfg_done_q && (timer_q == TMR_LAST);
      timer_d   = '0;
      if (cfg_done_q && !tick) begin
         timer_d = timer_q + TMR_W'(1);
      end
      start_rd  = (state_q == S_WAIT) && EN && (gap_q == '0) && (pending_q || tick);
      pending_d = start_rd ? 1'b0 : (pending_q || tick);
      in_frame  = ((state_q == S_CFG) || (state_q == S_READ)) && !cs_n_q;
      div_evt   = (div_q == DIV_LAST);
      last_byte = (state_q == S_CFG) ? 3'd2 : 3'd7;
      tx_cur    = tx_byte(state_q == S_CFG, byte_q);
      tx_bit    = tx_cur[3'd7 - bit_q];
   end

   // Sample timer and single-entry read request.
   always_ff @(posedge CLK) begin
      if (RST) begin
         timer_q   <= '0;
         pending_q <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         pending_q <= pending_d;
      end
   end

   // Receive shift register, loaded on every SCLK rising edge of a frame.
   always_ff @(posedge CLK) begin
      if (in_frame && div_evt && !sclk_q) begin
         rx_q <= {rx_q[46:0], MISO};
      end
   end

   // Main FSM with the shared bit/byte engine and registered pin outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_CFG;
         cs_n_q     <= 1'b1;
         sclk_q     <= 1'b1;
         mosi_q     <= 1'b0;
         valid_q    <= 1'b0;
         cfg_done_q <= 1'b0;
         div_q      <= '0;
         gap_q      <= '0;
         bit_q      <= '0;
         byte_q     <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         dz_q       <= '0;
      end else begin
         valid_q <= 1'b0;
         if (gap_q != '0) begin
            gap_q <= gap_q - DIV_W'(1);
         end
         case (state_q)
            S_CFG, S_READ: begin
               if (cs_n_q) begin
                  // Config frame launches on the first edge out of reset.
                  cs_n_q <= 1'b0;
                  div_q  <= '0;
                  bit_q  <= '0;
                  byte_q <= '0;
               end else if (!div_evt) begin
                  div_q <= div_q + DIV_W'(1);
               end else begin
                  div_q <= '0;
                  if (sclk_q) begin
                     if (byte_q == last_byte) begin
                        cs_n_q <= 1'b1;
                        gap_q  <= DIV_LAST;
                        if (state_q == S_CFG) begin
                           cfg_done_q <= 1'b1;
                           state_q    <= S_WAIT;
                        end else begin
                           dx_q    <= deadband({rx_q[39:32], rx_q[47:40]});
                           dy_q    <= deadband({rx_q[23:16], rx_q[31:24]});
                           dz_q    <= deadband({rx_q[7:0],   rx_q[15:8]});
                           valid_q <= 1'b1;
                           state_q <= S_LATCH;
                        end
                     end else begin
                        sclk_q <= 1'b0;
                        mosi_q <= tx_bit;
                     end
                  end else begin
                     sclk_q <= 1'b1;
                     bit_q  <= bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
                        byte_q <= byte_q + 3'd1;
                     end
                  end
               end
            end
            S_WAIT: begin
               if (start_rd) begin
                  state_q <= S_READ;
                  cs_n_q  <= 1'b0;
                  div_q   <= '0;
                  bit_q   <= '0;
                  byte_q  <= '0;
               end
            end
            S_LATCH: begin
               state_q <= S_WAIT;
            end
            default: begin
               state_q <= S_WAIT;
            end
         endcase
      end
   end

   assign SCLK     = sclk_q;
   assign CS_N     = cs_n_q;
   assign MOSI     = mosi_q;
   assign DX       = dx_q;
   assign DY       = dy_q;
   assign DZ       = dz_q;
   assign VALID    = valid_q;
   assign BUSY     = ~cs_n_q;
   assign CFG_DONE = cfg_done_q;

endmodule

// File: tb/tb_gyro_spi_reader.sv
// tb_gyro_spi_reader: mode-3 slave model plus reference checks for gyro_spi_reader.
module tb_gyro_spi_reader;

   localparam int D       = 4;
   localparam int SP      = 2000;
   localparam int CFG_LEN = 33 * D;
   localparam int RD_LEN  = 113 * D;

   logic               CLK = 1'b0;
   logic               RST = 1'b1;
   logic               EN  = 1'b0;
   logic               MISO = 1'b0;
   logic               SCLK, CS_N, MOSI, VALID, BUSY, CFG_DONE;
   logic signed [15:0] DX, DY, DZ;

   gyro_spi_reader #(.CLK_DIV(D), .SAMPLE_PERIOD(SP)) dut (
      .CLK(CLK), .RST(RST), .EN(EN), .SCLK(SCLK), .CS_N(CS_N), .MOSI(MOSI),
      .MISO(MISO), .DX(DX), .DY(DY), .DZ(DZ), .VALID(VALID), .BUSY(BUSY),
      .CFG_DONE(CFG_DONE)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   // Slave register image: index 0 is the command byte slot, 1..6 are XL..ZH.
   logic [7:0] sb [0:6];

   logic        prev_sclk = 1'b1, prev_cs = 1'b1, prev_vld = 1'b0, prev_cfg = 1'b0;
   int          nfall = 0, nrise = 0, fall_cyc = 0, last_rise = -100000;
   logic [55:0] shreg = '0;
   int          fr_start[$], fr_len[$], fr_bits[$];
   logic [55:0] fr_mosi[$];
   int          v_cyc[$];
   logic [15:0] v_dx[$], v_dy[$], v_dz[$];
   int          busy_bad = 0, vdbl = 0, vnoedge = 0, cfg_edge_bad = 0;
   int          cfg_rise = -1, min_gap = 1000000;

   // Pin monitor and mode-3 slave: drive MISO after SCLK falls, capture MOSI after it rises.
   always @(negedge CLK) begin
      prev_sclk <= SCLK;
      prev_cs   <= CS_N;
      prev_vld  <= VALID;
      prev_cfg  <= CFG_DONE;
      if (BUSY !== ~CS_N) busy_bad <= busy_bad + 1;
      if (prev_cs && !CS_N) begin
         fall_cyc <= cyc;
         nfall    <= 0;
         nrise    <= 0;
         shreg    <= '0;
         if (cyc - last_rise < min_gap) min_gap <= cyc - last_rise;
         fr_start.push_back(cyc);
      end else if (!CS_N) begin
         if (prev_sclk && !SCLK) begin
            MISO  <= sb[nfall / 8][7 - (nfall % 8)];
            nfall <= nfall + 1;
         end
         if (!prev_sclk && SCLK) begin
            shreg <= {shreg[54:0], MOSI};
            nrise <= nrise + 1;
         end
      end
      if (!prev_cs && CS_N) begin
         fr_len.push_back(cyc - fall_cyc);
         fr_mosi.push_back(shreg);
         fr_bits.push_back(nrise);
         last_rise <= cyc;
      end
      if (VALID) begin
         v_cyc.push_back(cyc);
         v_dx.push_back(DX);
         v_dy.push_back(DY);
         v_dz.push_back(DZ);
         if (prev_vld) vdbl <= vdbl + 1;
         if (!(!prev_cs && CS_N)) vnoedge <= vnoedge + 1;
      end
      if (CFG_DONE && !prev_cfg) begin
         cfg_rise <= cyc;
         if (!(!prev_cs && CS_N)) cfg_edge_bad <= cfg_edge_bad + 1;
      end
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge CLK);
      #1;
   endtask

   // Reference: assemble {hi,lo} as a signed rate, with the optional deadband.
   function automatic logic [15:0] model_axis(input logic [7:0] lo, input logic [7:0] hi);
      logic signed [15:0] v;
      v = {hi, lo};
`ifdef GYRO_DEADBAND_EN
      if ((v > -16'sd42) && (v < 16'sd10)) v = '0;
`endif
      return v;
   endfunction

   logic [15:0] ex, ey, ez;

   // New random slave sample; half the axes land near the deadband window.
   task automatic load_random();
      logic [15:0] v;
      sb[0] = 8'h00;
      for (int a = 0; a < 3; a++) begin
         if ($urandom_range(0, 1) == 1) v = 16'($urandom);
         else v = 16'(int'($urandom_range(0, 70)) - 50);
         sb[1 + 2 * a] = v[7:0];
         sb[2 + 2 * a] = v[15:8];
      end
      ex = model_axis(sb[1], sb[2]);
      ey = model_axis(sb[3], sb[4]);
      ez = model_axis(sb[5], sb[6]);
   endtask

   task automatic wait_valid(input int n, input int budget);
      int k = 0;
      while (v_cyc.size() < n && k < budget) begin step(); k++; end
      chk("wait_valid", v_cyc.size(), n);
   endtask

   task automatic wait_frames(input int n, input int budget);
      int k = 0;
      while (fr_len.size() < n && k < budget) begin step(); k++; end
      chk("wait_frame_end", fr_len.size(), n);
   endtask

   task automatic wait_start(input int n, input int budget);
      int k = 0;
      while (fr_start.size() < n && k < budget) begin step(); k++; end
      chk("wait_frame_start", fr_start.size(), n);
   endtask

   task automatic check_sample(input string tag, input int idx);
      if (v_cyc.size() > idx) begin
         chk({tag, "_dx"}, v_dx[idx], ex);
         chk({tag, "_dy"}, v_dy[idx], ey);
         chk({tag, "_dz"}, v_dz[idx], ez);
      end
   endtask

   initial begin
      int rel, ns, nf, nv, c, k;
      for (int i = 0; i < 7; i++) sb[i] = 8'h00;

      // Reset state
      RST = 1'b1;
      EN  = 1'b0;
      repeat (3) step();
      chk("rst_sclk", SCLK, 1'b1);
      chk("rst_cs_n", CS_N, 1'b1);
      chk("rst_mosi", MOSI, 1'b0);
      chk("rst_dx", DX, 16'h0);
      chk("rst_dy", DY, 16'h0);
      chk("rst_dz", DZ, 16'h0);
      chk("rst_valid", VALID, 1'b0);
      chk("rst_busy", BUSY, 1'b0);
      chk("rst_cfg_done", CFG_DONE, 1'b0);

      // Config frame, then first read with the directed sample
      sb[1] = 8'h34; sb[2] = 8'h12; sb[3] = 8'hCD; sb[4] = 8'hAB; sb[5] = 8'h00; sb[6] = 8'h80;
      ex = 16'h1234; ey = 16'hABCD; ez = 16'h8000;
      EN  = 1'b1;
      RST = 1'b0;
      rel = cyc;
      wait_frames(1, CFG_LEN + 20);
      if (fr_len.size() >= 1) begin
         chk("cfg_start", fr_start[0], rel + 1);
         chk("cfg_len", fr_len[0], CFG_LEN);
         chk("cfg_bits", fr_bits[0], 16);
         chk("cfg_mosi", fr_mosi[0][15:0], 16'h200F);
         chk("cfg_done_rise", cfg_rise, fr_start[0] + CFG_LEN);
      end
      chk("cfg_no_valid", v_cyc.size(), 0);

      wait_valid(1, SP + RD_LEN + 50);
      if (v_cyc.size() >= 1) chk("rd0_valid_cyc", v_cyc[0], cfg_rise + SP + RD_LEN);
      if (fr_len.size() >= 2) begin
         chk("rd0_len", fr_len[1], RD_LEN);
         chk("rd0_bits", fr_bits[1], 56);
         chk("rd0_mosi", fr_mosi[1], 56'hE8_0000_0000_0000);
      end
      check_sample("rd0", 0);

      // Cadence with random samples
      for (int i = 1; i < 5; i++) begin
         load_random();
         wait_valid(i + 1, SP + 50);
         check_sample("rd_rand", i);
         if (v_cyc.size() > i) chk("cadence", v_cyc[i] - v_cyc[i - 1], SP);
      end

      // Deadband boundaries: -41 is inside, 10 and -42 are outside
      sb[0] = 8'h00;
      sb[1] = 8'hD7; sb[2] = 8'hFF; sb[3] = 8'h0A; sb[4] = 8'h00; sb[5] = 8'hD6; sb[6] = 8'hFF;
`ifdef GYRO_DEADBAND_EN
      ex = 16'h0000;
`else
      ex = 16'hFFD7;
`endif
      ey = 16'h000A;
      ez = 16'hFFD6;
      wait_valid(6, SP + 50);
      check_sample("deadband", 5);
      if (v_cyc.size() > 5) chk("cadence_db", v_cyc[5] - v_cyc[4], SP);

      chk("busy_eq_not_cs", busy_bad, 0);
      chk("valid_one_cycle", vdbl, 0);
      chk("valid_at_cs_rise", vnoedge, 0);
      chk("cfg_done_at_cs_rise", cfg_edge_bad, 0);
      chk("frame_gap_ge_d", (min_gap >= D), 1'b1);
      chk("frames_vs_valids", fr_len.size(), v_cyc.size() + 1);

      // Enable dropped mid-frame: frame still latches, no further frames
      load_random();
      ns = fr_start.size();
      wait_start(ns + 1, SP + 50);
      repeat (100) step();
      EN = 1'b0;
      wait_valid(7, RD_LEN);
      check_sample("en_low_inflight", 6);
      nf = fr_start.size();
      repeat (2600) step();
      chk("en_low_no_frame", fr_start.size(), nf);

      // Enable raised with a tick pending: read starts on the next edge
      load_random();
      EN = 1'b1;
      c  = cyc;
      step();
      step();
      chk("en_rise_frame", fr_start.size(), nf + 1);
      chk("en_rise_latency", (fr_start.size() > nf) ? fr_start[nf] : -1, c + 1);
      wait_valid(8, RD_LEN + 20);
      check_sample("en_rise_read", 7);

      // Reset in the middle of a read frame
      load_random();
      ns = fr_start.size();
      wait_start(ns + 1, SP + 50);
      k = 0;
      while (nrise < 20 && k < 400) begin step(); k++; end
      chk("rst_mid_bits_reached", (nrise >= 20), 1'b1);
      RST = 1'b1;
      nv  = v_cyc.size();
      step();
      chk("rstmid_cs_n", CS_N, 1'b1);
      chk("rstmid_sclk", SCLK, 1'b1);
      chk("rstmid_dx", DX, 16'h0);
      chk("rstmid_dy", DY, 16'h0);
      chk("rstmid_dz", DZ, 16'h0);
      chk("rstmid_valid", VALID, 1'b0);
      chk("rstmid_cfg_done", CFG_DONE, 1'b0);
      chk("rstmid_no_valid", v_cyc.size(), nv);
      if (fr_bits.size() > 0) chk("rstmid_aborted", (fr_bits[fr_bits.size() - 1] < 56), 1'b1);
      step();
      nf  = fr_len.size();
      RST = 1'b0;
      rel = cyc;
      wait_frames(nf + 1, CFG_LEN + 20);
      if (fr_len.size() > nf) begin
         chk("recfg_start", fr_start[nf], rel + 1);
         chk("recfg_len", fr_len[nf], CFG_LEN);
         chk("recfg_bits", fr_bits[nf], 16);
         chk("recfg_mosi", fr_mosi[nf][15:0], 16'h200F);
         chk("recfg_done_rise", cfg_rise, fr_start[nf] + CFG_LEN);
      end
      chk("busy_eq_not_cs_end", busy_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Absolute time limit in case the sequence stalls.
   initial begin
      #2000000;
      $display("FAIL global_timeout: observed no finish, expected finish before time limit");
      $fatal(1, "simulation time limit reached");
   end

endmodule
